id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage that produces the operation bundle consumed by the execute stage: aluop, alusel, reg1, reg2, wd, wreg.
- Decodes one 32-bit MIPS instruction per cycle and reads two register-file ports.
- Resolves operand bypass from the EXE and MEM results.
- Registers the bundle in an ID/EX pipeline register with stall and flush control.

Parameters:
- RESET_WORD, 32'h00000000, value loaded into reg1_o/reg2_o on reset or flush.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  reset; one clock; reset is asynchronous and active-high (resetn==1 resets).
- inst_valid_i  in  1  inst_i holds a real instruction this cycle.
- inst_i  in  32  instruction word.
- inst_ready_o  out  1  stage accepts inst_i this cycle; equals ~stall_i.
- stall_i  in  1  hold the ID/EX register.
- flush_i  in  1  replace the ID/EX contents with a bubble.
- re1_o, re2_o  out  1 each  register-file read enables.
- raddr1_o, raddr2_o  out  5 each  read addresses (rs, rt).
- rdata1_i, rdata2_i  in  32 each  read data.
- ex_wreg_i, ex_wd_i, ex_wdata_i  in  1/5/32  EXE-stage result, for bypass.
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/5/32  MEM-stage result, for bypass.
- aluop_o  out  8  registered ALU op.
- alusel_o  out  3  registered result select.
- reg1_o, reg2_o  out  32 each  registered operands.
- wd_o  out  5  registered destination register.
- wreg_o  out  1  registered write enable.
- invalid_o  out  1  registered reserved-instruction flag.

Behaviour:
- Encodings, shared with EXE:
  - aluop: NOP 8'h00, OR 8'h25, AND 8'h24, XOR 8'h26, NOR 8'h27, SLL 8'h7C, SRL 8'h02, SRA 8'h03.
  - alusel: NOP 000, LOGIC 001, SHIFT 010.
- Decode is combinational from inst_i; read ports are combinational.
- ID/EX register latency is 1 cycle: outputs change only at a posedge, or on async reset.
- Reset (resetn=1), async: aluop=NOP, alusel=NOP, reg1=reg2=RESET_WORD, wd=0, wreg=0, invalid=0. While reset is held, re1_o=re2_o=0.
- Priority at each posedge: flush_i > stall_i > load.
  - flush: load the bubble, i.e. the reset values.
  - stall: hold all outputs.
  - load with inst_valid_i=0: load the bubble.
  - load with inst_valid_i=1: load the decoded bundle.
- R-type (opcode 0), wd=rd:
  - or/and/xor/nor (funct 25/24/26/27): LOGIC; reg1=rs, reg2=rt.
  - sll/srl (funct 00/02): SHIFT; reg1=rt, reg2={27'b0,sa}; re1=0.
  - sra (funct 03): SHIFT; reg1={27'b0,sa}, reg2=rt; re1=0.
  - sllv/srlv (04/06): SLL/SRL ops; reg1=rt, reg2=rs.
  - srav (07): SRA op; reg1=rs, reg2=rt.
- I-type, wd=rt, re2=0, all LOGIC:
  - ori 0D: OR; reg2={16'b0,imm}.
  - andi 0C: AND; reg2={16'b0,imm}.
  - xori 0E: XOR; reg2={16'b0,imm}.
  - lui 0F: OR; reg1=0, reg2={imm,16'b0}.
- Any other opcode/funct: invalid=1, bundle is a bubble, re1=re2=0.
- wreg=1 for every valid decoded instruction except when wd==0. wreg=0 for wd==0, so all-zero nop yields aluop SLL, wreg 0.
- Operand source, per port, highest priority first:
  1. address 0 → 0.
  2. ex_wreg_i && ex_wd_i==addr → ex_wdata_i.
  3. mem_wreg_i && mem_wd_i==addr → mem_wdata_i.
  4. rdata_i.
- A disabled read port contributes 0; the immediate/sa substitution applies after bypass selection.
- No load-use hazard exists; the stage never generates stalls itself.

Decomposition:
- Package mips_defs_pkg holds:
  - aluop and alusel constants;
  - opcode/funct constants (OR..SRAV, ORI..LUI);
  - a struct for the ID/EX bundle.
- Sub-module id_decode_core (combinational decode plus bypass muxes) is instantiated in id_stage, which owns only the pipeline register and the stall/flush logic.

Test Plan:
- ori $1,$0,0x1100 (0x34011100, valid): next edge → aluop 0x25, alusel 001, reg1 0, reg2 0x00001100, wd 1, wreg 1. Then lui $4,0xABCD (0x3C04ABCD) → reg1 0, reg2 0xABCD0000, wd 4.
- Bypass priority: ori $2,$1,0x20 (0x34220020) with ex_wreg=1/ex_wd=1/ex_wdata=0x1100, mem_wreg=1/mem_wd=1/mem_wdata=0x5555, rdata1=0xDEAD → reg1 0x1100. Same with ex_wreg=0 → reg1 0x5555. Same with rs=0 and EXE forwarding to $0 → reg1 0.
- sra $3,$2,4 (0x00021903), rdata2=0x80000000 → aluop 0x03, alusel 010, reg1 0x00000004, reg2 0x80000000, wd 3, re1_o 0. sll $3,$2,4 (0x00021900) → reg1 0x80000000, reg2 4.
- Load an or, then assert stall_i for 3 cycles with new instructions on inst_i → outputs unchanged and inst_ready_o=0. Then stall_i=1 and flush_i=1 together → bubble (aluop 0, wreg 0) next edge.
- inst 0xFC000000 valid → invalid_o 1, aluop 0, alusel 0, wreg 0. inst_valid_i=0 with any inst_i → bubble, invalid_o 0. Inst 0x00000000 → aluop 0x7C, wreg 0.
- Assert resetn between clock edges while the or bundle is held → all outputs zero immediately, before the next edge. Deassert and load ori → normal decode on the following edge.

Source files
------------

// File: rtl/mips_defs_pkg.sv
// rtl/mips_defs_pkg.sv - shared MIPS decode encodings and ID/EX bundle type
//
// Purpose: aluop/alusel encodings shared with EXE, opcode/funct constants
// decoded by ID, operand-source selector and the ID/EX bundle struct.
// Ports: none (package).
package mips_defs_pkg;

   localparam logic [7:0] ALUOP_NOP = 8'h00;
   localparam logic [7:0] ALUOP_OR  = 8'h25;
   localparam logic [7:0] ALUOP_AND = 8'h24;
   localparam logic [7:0] ALUOP_XOR = 8'h26;
   localparam logic [7:0] ALUOP_NOR = 8'h27;
   localparam logic [7:0] ALUOP_SLL = 8'h7C;
   localparam logic [7:0] ALUOP_SRL = 8'h02;
   localparam logic [7:0] ALUOP_SRA = 8'h03;

   localparam logic [2:0] ALUSEL_NOP   = 3'b000;
   localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
   localparam logic [2:0] ALUSEL_SHIFT = 3'b010;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;

   localparam logic [5:0] FUNCT_SLL  = 6'h00;
   localparam logic [5:0] FUNCT_SRL  = 6'h02;
   localparam logic [5:0] FUNCT_SRA  = 6'h03;
   localparam logic [5:0] FUNCT_SLLV = 6'h04;
   localparam logic [5:0] FUNCT_SRLV = 6'h06;
   localparam logic [5:0] FUNCT_SRAV = 6'h07;
   localparam logic [5:0] FUNCT_AND  = 6'h24;
   localparam logic [5:0] FUNCT_OR   = 6'h25;
   localparam logic [5:0] FUNCT_XOR  = 6'h26;
   localparam logic [5:0] FUNCT_NOR  = 6'h27;

   // Where each registered operand comes from once bypass is resolved.
   typedef enum logic [2:0] {
      SRC_RESET,   // bubble value
      SRC_PORT1,   // bypassed read port 1 (rs)
      SRC_PORT2,   // bypassed read port 2 (rt)
      SRC_SA,      // zero-extended shift amount
      SRC_IMM_ZX,  // zero-extended immediate
      SRC_IMM_HI,  // immediate in the upper half (lui)
      SRC_ZERO
   } opnd_src_e;

   typedef struct packed {
      logic [7:0]  aluop;
      logic [2:0]  alusel;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic        invalid;
   } id_ex_t;

   function automatic id_ex_t make_bubble(input logic [31:0] word);
      id_ex_t b;
      b.aluop   = ALUOP_NOP;
      b.alusel  = ALUSEL_NOP;
      b.reg1    = word;
      b.reg2    = word;
      b.wd      = 5'd0;
      b.wreg    = 1'b0;
      b.invalid = 1'b0;
      return b;
   endfunction

endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - instruction handshake between fetch and decode
//
// Purpose: carries the instruction word into ID with its valid/ready pair.
// Ports (signals): inst_valid, inst[31:0] from fetch; inst_ready from ID.
// Modports: master = fetch side, slave = decode side.
interface id_stage_if;
   logic        inst_valid;
   logic [31:0] inst;
   logic        inst_ready;

   modport master (output inst_valid, output inst, input inst_ready);
   modport slave  (input inst_valid, input inst, output inst_ready);
endinterface

// File: rtl/id_decode_core.sv
// rtl/id_decode_core.sv - combinational MIPS decode plus operand bypass
//
// Purpose: decodes one instruction, drives register-file read ports,
// resolves EXE/MEM bypass and assembles the unregistered ID/EX bundle.
// Ports: inst in; re1/re2, raddr1/raddr2 out; rdata1/rdata2 in;
// ex_*/mem_* bypass sources in; bundle out (id_ex_t).
module id_decode_core
   import mips_defs_pkg::*;
#(
   parameter logic [31:0] RESET_WORD = 32'h00000000
) (
   input  logic [31:0] inst,
   output logic        re1,
   output logic        re2,
   output logic [4:0]  raddr1,
   output logic [4:0]  raddr2,
   input  logic [31:0] rdata1,
   input  logic [31:0] rdata2,
   input  logic        ex_wreg,
   input  logic [4:0]  ex_wd,
   input  logic [31:0] ex_wdata,
   input  logic        mem_wreg,
   input  logic [4:0]  mem_wd,
   input  logic [31:0] mem_wdata,
   output id_ex_t      bundle
);

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, sa;
   logic [15:0] imm;

   assign op    = inst[31:26];
   assign rs    = inst[25:21];
   assign rt    = inst[20:16];
   assign rd    = inst[15:11];
   assign sa    = inst[10:6];
   assign funct = inst[5:0];
   assign imm   = inst[15:0];

   assign raddr1 = rs;
   assign raddr2 = rt;

   logic        valid;
   logic [7:0]  aluop;
   logic [2:0]  alusel;
   logic [4:0]  wd;
   opnd_src_e   src1, src2;

   // Control decode only; operand values are assembled separately so the
   // read enables never depend on the bypassed data.
   always_comb begin
      valid  = 1'b0;
      re1    = 1'b0;
      re2    = 1'b0;
      aluop  = ALUOP_NOP;
      alusel = ALUSEL_NOP;
      wd     = 5'd0;
      src1   = SRC_RESET;
      src2   = SRC_RESET;
      if (op == OP_SPECIAL) begin
         valid  = 1'b1;
         wd     = rd;
         re1    = 1'b1;
         re2    = 1'b1;
         alusel = ALUSEL_LOGIC;
         src1   = SRC_PORT1;
         src2   = SRC_PORT2;
         case (funct)
            FUNCT_OR:  aluop = ALUOP_OR;
            FUNCT_AND: aluop = ALUOP_AND;
            FUNCT_XOR: aluop = ALUOP_XOR;
            FUNCT_NOR: aluop = ALUOP_NOR;
            FUNCT_SLL, FUNCT_SRL: begin
               aluop  = (funct == FUNCT_SLL) ? ALUOP_SLL : ALUOP_SRL;
               alusel = ALUSEL_SHIFT;
               re1    = 1'b0;
               src1   = SRC_PORT2;
               src2   = SRC_SA;
            end
            FUNCT_SRA: begin
               aluop  = ALUOP_SRA;
               alusel = ALUSEL_SHIFT;
               re1    = 1'b0;
               src1   = SRC_SA;
               src2   = SRC_PORT2;
            end
            FUNCT_SLLV, FUNCT_SRLV: begin
               aluop  = (funct == FUNCT_SLLV) ? ALUOP_SLL : ALUOP_SRL;
               alusel = ALUSEL_SHIFT;
               src1   = SRC_PORT2;
               src2   = SRC_PORT1;
            end
            FUNCT_SRAV: begin
               aluop  = ALUOP_SRA;
               alusel = ALUSEL_SHIFT;
            end
            default: valid = 1'b0;
         endcase
      end else if (op == OP_ORI || op == OP_ANDI || op == OP_XORI || op == OP_LUI) begin
         valid  = 1'b1;
         wd     = rt;
         re1    = 1'b1;
         alusel = ALUSEL_LOGIC;
         src1   = SRC_PORT1;
         src2   = SRC_IMM_ZX;
         case (op)
            OP_ANDI: aluop = ALUOP_AND;
            OP_XORI: aluop = ALUOP_XOR;
            OP_LUI: begin
               aluop = ALUOP_OR;
               src1  = SRC_ZERO;
               src2  = SRC_IMM_HI;
            end
            default: aluop = ALUOP_OR;
         endcase
      end
      // Anything unrecognised collapses to a bubble with both ports idle.
      if (!valid) begin
         re1    = 1'b0;
         re2    = 1'b0;
         aluop  = ALUOP_NOP;
         alusel = ALUSEL_NOP;
         wd     = 5'd0;
         src1   = SRC_RESET;
         src2   = SRC_RESET;
      end
   end

   // $0 always reads zero; the younger EXE result wins over MEM.
   function automatic logic [31:0] bypass(
      input logic        en,
      input logic [4:0]  addr,
      input logic [31:0] rdata,
      input logic        x_wreg,
      input logic [4:0]  x_wd,
      input logic [31:0] x_wdata,
      input logic        m_wreg,
      input logic [4:0]  m_wd,
      input logic [31:0] m_wdata
   );
      if (!en || addr == 5'd0)             return 32'h0;
      else if (x_wreg && x_wd == addr)     return x_wdata;
      else if (m_wreg && m_wd == addr)     return m_wdata;
      else                                 return rdata;
   endfunction

   logic [31:0] port1, port2;

   assign port1 = bypass(re1, rs, rdata1, ex_wreg, ex_wd, ex_wdata, mem_wreg, mem_wd, mem_wdata);
   assign port2 = bypass(re2, rt, rdata2, ex_wreg, ex_wd, ex_wdata, mem_wreg, mem_wd, mem_wdata);

   function automatic logic [31:0] pick(input opnd_src_e s, input logic [31:0] p1,
                                        input logic [31:0] p2, input logic [4:0] s_amt,
                                        input logic [15:0] s_imm);
      case (s)
         SRC_PORT1:  return p1;
         SRC_PORT2:  return p2;
         SRC_SA:     return {27'b0, s_amt};
         SRC_IMM_ZX: return {16'b0, s_imm};
         SRC_IMM_HI: return {s_imm, 16'b0};
         SRC_ZERO:   return 32'h0;
         default:    return RESET_WORD;
      endcase
   endfunction

   always_comb begin
      bundle         = make_bubble(RESET_WORD);
      bundle.aluop   = aluop;
      bundle.alusel  = alusel;
      bundle.reg1    = pick(src1, port1, port2, sa, imm);
      bundle.reg2    = pick(src2, port1, port2, sa, imm);
      bundle.wd      = wd;
      bundle.wreg    = valid && (wd != 5'd0);
      bundle.invalid = !valid;
   end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS ID stage: decode core plus ID/EX pipeline register
//
// Purpose: registers the decoded bundle with flush > stall > load priority.
// Ports: clk, resetn (async, active-high); fetch (id_stage_if.slave);
// stall_i, flush_i; re1_o/re2_o, raddr1_o/raddr2_o, rdata1_i/rdata2_i;
// ex_*_i / mem_*_i bypass; aluop_o, alusel_o, reg1_o, reg2_o, wd_o,
// wreg_o, invalid_o (registered).
module id_stage
   import mips_defs_pkg::*;
#(
   parameter logic [31:0] RESET_WORD = 32'h00000000
) (
   input  logic        clk,
   input  logic        resetn,
   id_stage_if.slave   fetch,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        re1_o,
   output logic        re2_o,
   output logic [4:0]  raddr1_o,
   output logic [4:0]  raddr2_o,
   input  logic [31:0] rdata1_i,
   input  logic [31:0] rdata2_i,
   input  logic        ex_wreg_i,
   input  logic [4:0]  ex_wd_i,
   input  logic [31:0] ex_wdata_i,
   input  logic        mem_wreg_i,
   input  logic [4:0]  mem_wd_i,
   input  logic [31:0] mem_wdata_i,
   output logic [7:0]  aluop_o,
   output logic [2:0]  alusel_o,
   output logic [31:0] reg1_o,
   output logic [31:0] reg2_o,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic        invalid_o
);

   localparam id_ex_t BUBBLE = make_bubble(RESET_WORD);

   logic   core_re1, core_re2;
   id_ex_t dec, bundle_q;

   id_decode_core #(.RESET_WORD(RESET_WORD)) u_core (
      .inst      (fetch.inst),
      .re1       (core_re1),
      .re2       (core_re2),
      .raddr1    (raddr1_o),
      .raddr2    (raddr2_o),
      .rdata1    (rdata1_i),
      .rdata2    (rdata2_i),
      .ex_wreg   (ex_wreg_i),
      .ex_wd     (ex_wd_i),
      .ex_wdata  (ex_wdata_i),
      .mem_wreg  (mem_wreg_i),
      .mem_wd    (mem_wd_i),
      .mem_wdata (mem_wdata_i),
      .bundle    (dec)
   );

   // The register file stays quiet while reset is held.
   assign re1_o = core_re1 & ~resetn;
   assign re2_o = core_re2 & ~resetn;

   assign fetch.inst_ready = ~stall_i;

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn)
         bundle_q <= BUBBLE;
      else if (flush_i)
         bundle_q <= BUBBLE;
      else if (!stall_i)
         bundle_q <= fetch.inst_valid ? dec : BUBBLE;
   end

   assign aluop_o   = bundle_q.aluop;
   assign alusel_o  = bundle_q.alusel;
   assign reg1_o    = bundle_q.reg1;
   assign reg2_o    = bundle_q.reg2;
   assign wd_o      = bundle_q.wd;
   assign wreg_o    = bundle_q.wreg;
   assign invalid_o = bundle_q.invalid;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        stall_i, flush_i;
   logic        re1_o, re2_o;
   logic [4:0]  raddr1_o, raddr2_o;
   logic [31:0] rdata1_i, rdata2_i;
   logic        ex_wreg_i, mem_wreg_i;
   logic [4:0]  ex_wd_i, mem_wd_i;
   logic [31:0] ex_wdata_i, mem_wdata_i;
   logic [7:0]  aluop_o;
   logic [2:0]  alusel_o;
   logic [31:0] reg1_o, reg2_o;
   logic [4:0]  wd_o;
   logic        wreg_o, invalid_o;

   int checks = 0;
   int errors = 0;

   // {aluop, alusel, reg1, reg2, wd, wreg, invalid}
   logic [81:0] obs;
   assign obs = {aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, invalid_o};

   always #5 clk = ~clk;

   id_stage_if fetch_if ();

   id_stage #(.RESET_WORD(32'h00000000)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .fetch       (fetch_if),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .re1_o       (re1_o),
      .re2_o       (re2_o),
      .raddr1_o    (raddr1_o),
      .raddr2_o    (raddr2_o),
      .rdata1_i    (rdata1_i),
      .rdata2_i    (rdata2_i),
      .ex_wreg_i   (ex_wreg_i),
      .ex_wd_i     (ex_wd_i),
      .ex_wdata_i  (ex_wdata_i),
      .mem_wreg_i  (mem_wreg_i),
      .mem_wd_i    (mem_wd_i),
      .mem_wdata_i (mem_wdata_i),
      .aluop_o     (aluop_o),
      .alusel_o    (alusel_o),
      .reg1_o      (reg1_o),
      .reg2_o      (reg2_o),
      .wd_o        (wd_o),
      .wreg_o      (wreg_o),
      .invalid_o   (invalid_o)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fwd;
      ex_wreg_i   = 1'b0; ex_wd_i  = 5'd0; ex_wdata_i  = 32'h0;
      mem_wreg_i  = 1'b0; mem_wd_i = 5'd0; mem_wdata_i = 32'h0;
   endtask

   task automatic issue(input logic [31:0] word);
      fetch_if.inst_valid = 1'b1;
      fetch_if.inst       = word;
   endtask

   task automatic test_reset;
      logic [81:0] exp;
      exp = {8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
      resetn = 1'b1;
      stall_i = 1'b0; flush_i = 1'b0;
      rdata1_i = 32'h0; rdata2_i = 32'h0;
      clear_fwd();
      issue(32'h00222825);
      tick();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_bundle got %h exp %h", obs, exp); end
      checks++;
      if ({re1_o, re2_o} !== 2'b00) begin errors++; $display("FAIL reset_re got %b exp 00", {re1_o, re2_o}); end
      checks++;
      if (fetch_if.inst_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fetch_if.inst_ready); end
      resetn = 1'b0;
   endtask

   task automatic test_logic_imm;
      logic [81:0] exp;
      rdata1_i = 32'hDEADBEEF; rdata2_i = 32'h12345678;
      issue(32'h34011100);
      #1;
      checks++;
      if ({re1_o, re2_o} !== 2'b10) begin errors++; $display("FAIL ori_re got %b exp 10", {re1_o, re2_o}); end
      tick();
      exp = {8'h25, 3'b001, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ori got %h exp %h", obs, exp); end
      issue(32'h3C04ABCD);
      tick();
      exp = {8'h25, 3'b001, 32'h0, 32'hABCD0000, 5'd4, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL lui got %h exp %h", obs, exp); end
   endtask

   task automatic test_bypass;
      logic [81:0] exp;
      rdata1_i = 32'h0000DEAD;
      ex_wreg_i  = 1'b1; ex_wd_i  = 5'd1; ex_wdata_i  = 32'h00001100;
      mem_wreg_i = 1'b1; mem_wd_i = 5'd1; mem_wdata_i = 32'h00005555;
      issue(32'h34220020);
      #1;
      checks++;
      if (raddr1_o !== 5'd1) begin errors++; $display("FAIL byp_raddr1 got %0d exp 1", raddr1_o); end
      tick();
      exp = {8'h25, 3'b001, 32'h00001100, 32'h00000020, 5'd2, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL byp_ex got %h exp %h", obs, exp); end
      ex_wreg_i = 1'b0;
      tick();
      exp = {8'h25, 3'b001, 32'h00005555, 32'h00000020, 5'd2, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL byp_mem got %h exp %h", obs, exp); end
      mem_wreg_i = 1'b0;
      tick();
      exp = {8'h25, 3'b001, 32'h0000DEAD, 32'h00000020, 5'd2, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL byp_rf got %h exp %h", obs, exp); end
      ex_wreg_i = 1'b1; ex_wd_i = 5'd0; ex_wdata_i = 32'h00001100;
      issue(32'h34020020);
      tick();
      exp = {8'h25, 3'b001, 32'h0, 32'h00000020, 5'd2, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL byp_zero got %h exp %h", obs, exp); end
      clear_fwd();
   endtask

   task automatic test_shift;
      logic [81:0] exp;
      rdata1_i = 32'h0000DEAD; rdata2_i = 32'h80000000;
      issue(32'h00021903);
      #1;
      checks++;
      if ({re1_o, re2_o} !== 2'b01) begin errors++; $display("FAIL sra_re got %b exp 01", {re1_o, re2_o}); end
      tick();
      exp = {8'h03, 3'b010, 32'h00000004, 32'h80000000, 5'd3, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL sra got %h exp %h", obs, exp); end
      issue(32'h00021900);
      tick();
      exp = {8'h7C, 3'b010, 32'h80000000, 32'h00000004, 5'd3, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL sll got %h exp %h", obs, exp); end
      issue(32'h00223006);
      tick();
      exp = {8'h02, 3'b010, 32'h80000000, 32'h0000DEAD, 5'd6, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL srlv got %h exp %h", obs, exp); end
   endtask

   task automatic test_stall_flush;
      logic [81:0] exp;
      logic [31:0] others [3];
      others[0] = 32'h34011100;
      others[1] = 32'h00021903;
      others[2] = 32'h3C04ABCD;
      rdata1_i = 32'h0F0F0000; rdata2_i = 32'h000000F0;
      issue(32'h00222825);
      tick();
      exp = {8'h25, 3'b001, 32'h0F0F0000, 32'h000000F0, 5'd5, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL or_load got %h exp %h", obs, exp); end
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(others[i]);
         #1;
         checks++;
         if (fetch_if.inst_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d got %b exp 0", i, fetch_if.inst_ready); end
         tick();
         checks++;
         if (obs !== exp) begin errors++; $display("FAIL stall_hold%0d got %h exp %h", i, obs, exp); end
      end
      flush_i = 1'b1;
      tick();
      exp = {8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL flush got %h exp %h", obs, exp); end
      stall_i = 1'b0; flush_i = 1'b0;
   endtask

   task automatic test_invalid;
      logic [81:0] exp;
      rdata1_i = 32'h11111111; rdata2_i = 32'h22222222;
      issue(32'hFC000000);
      #1;
      checks++;
      if ({re1_o, re2_o} !== 2'b00) begin errors++; $display("FAIL inv_re got %b exp 00", {re1_o, re2_o}); end
      tick();
      exp = {8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL invalid got %h exp %h", obs, exp); end
      fetch_if.inst_valid = 1'b0;
      fetch_if.inst = 32'h34011100;
      tick();
      exp = {8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL not_valid got %h exp %h", obs, exp); end
      issue(32'h00000000);
      tick();
      exp = {8'h7C, 3'b010, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL nop got %h exp %h", obs, exp); end
   endtask

   task automatic test_async_reset;
      logic [81:0] exp;
      rdata1_i = 32'h0F0F0000; rdata2_i = 32'h000000F0;
      issue(32'h00222825);
      tick();
      exp = {8'h25, 3'b001, 32'h0F0F0000, 32'h000000F0, 5'd5, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ar_load got %h exp %h", obs, exp); end
      #2;
      resetn = 1'b1;
      #1;
      exp = {8'h00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ar_clear got %h exp %h", obs, exp); end
      checks++;
      if ({re1_o, re2_o} !== 2'b00) begin errors++; $display("FAIL ar_re got %b exp 00", {re1_o, re2_o}); end
      @(negedge clk);
      resetn = 1'b0;
      issue(32'h34011100);
      tick();
      exp = {8'h25, 3'b001, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b0};
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL ar_ori got %h exp %h", obs, exp); end
   endtask

   initial begin
      test_reset();
      test_logic_imm();
      test_bypass();
      test_shift();
      test_stall_flush();
      test_invalid();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
